npc_seq: RTL and testbench
==========================

Name: npc_seq

Overview:
- Parametrised next-PC sequencer for the MIPS datapath. It owns the fetch PC register and resolves branch, jump, exception and eret redirects each cycle.
- Decode supplies the condition flags and the instruction word; outputs feed IM addressing and the F/D pipeline register.
- Adds a return-address stack (RAS) that tracks jal/jr pairs and counts return mispredictions for performance monitoring.

Parameters:
- WIDTH, 32, PC/data width (minimum 28).
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, exception entry address.
- RAS_DEPTH, 4, number of RAS entries (power of two, at least 2).
- CNT_W, 16, width of the misprediction counter.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- stall  in  1  hold the PC (hazard unit).
- instr  in  32  instruction in D stage; imm16=[15:0], index=[25:0].
- pc4_d  in  WIDTH  PC+4 of the D-stage instruction.
- br_type  in  3  0 none, 1 beq, 2 bne, 3 bgez, 4 bltz, 5 bgtz, 6 blez, 7 reserved (treated as none).
- zero, bgez, bgtz, blez, bltz  in  1 each  comparator flags.
- j_sel  in  2  0 none, 1 j, 2 jal, 3 jr.
- rs_val  in  WIDTH  forwarded GPR[rs] for jr.
- exc_req  in  1  exception taken this cycle.
- eret  in  1  return from exception.
- epc  in  WIDTH  CP0 EPC.
- pc  out  WIDTH  current fetch PC (register).
- pc4  out  WIDTH  pc+4 (combinational).
- ras_top  out  WIDTH  top RAS entry; 0 when the RAS is empty.
- ras_cnt  out  log2(RAS_DEPTH)+1  valid entry count.
- ras_miss  out  CNT_W  saturating jr misprediction count.

Behaviour:
- Reset (reset==0 at posedge): pc=RESET_PC; RAS pointer, count and entries = 0; ras_miss=0. Reset overrides all other inputs, including mid-stall and mid-exception.
- Next-PC priority, evaluated each posedge (first matching rule wins):
  - exc_req: pc=EXC_VEC.
  - eret: pc=epc.
  - stall: pc held.
  - Taken branch: pc = pc4_d + (sext(imm16)<<2).
  - j/jal: pc = {pc4_d[WIDTH-1:28], index, 2'b00}.
  - jr: pc = rs_val.
  - Otherwise: pc = pc+4.
- exc_req and eret override stall.
- Branch taken conditions:
  - type 1: zero==1.
  - type 2: zero==0.
  - types 3–6: the corresponding flag==1.
  - Branch has priority over j_sel if both are asserted.
- All adds are modulo 2^WIDTH; wrap-around is silent.
- Target is 1-cycle latency: the redirect is visible on pc the cycle after the D-stage inputs are presented.
- RAS updates only on cycles where the redirect actually applies (no reset, no exc_req/eret, no stall, no taken branch):
  - jal pushes pc4_d+4 (return past the delay slot).
  - When full, a push overwrites the oldest entry (circular pointer wraps); count saturates at RAS_DEPTH.
  - jr with count>0 pops; if the popped value != rs_val, ras_miss increments, saturating at all-ones.
  - jr with count==0: no pop, no count change.
- Push and pop can never occur in the same cycle (j_sel is exclusive).
- Exceptions and eret leave the RAS unchanged.
- pc4 and ras_top are combinational from registered state only.

Test Plan:
- Reset hold, then release: pc=0x3000; following cycles 0x3004, 0x3008. Assert reset mid-run at pc=0x3010 → pc=0x3000 next cycle, ras_cnt=0.
- beq, zero=1, pc4_d=0x3004, imm16=0xFFFF → pc=0x3000. Same stimulus with zero=0 → pc=pc+4. bltz with bltz=1, imm16=0x0004 → pc=0x3014.
- jal, pc4_d=0x3008, index=0x0000C10 → pc=0x3040, ras_top=0x300C, ras_cnt=1. Then jr with rs_val=0x300C → pc=0x300C, ras_cnt=0, ras_miss=0. A jr with rs_val=0x4000 after a fresh jal → ras_miss=1.
- Five jal pushes with RAS_DEPTH=4 → ras_cnt=4, oldest entry overwritten. Four matching jr pops return the last four addresses in LIFO order. A fifth jr → no pop, ras_miss unchanged.
- stall=1 together with jal → pc held, RAS unchanged. stall=1 with exc_req=1 → pc=0x4180. eret with epc=0x3020 while stalled → pc=0x3020.
- Branch and j_sel=jal asserted together, branch taken → branch target taken, no RAS push.

Source files
------------

// File: rtl/npc_seq.sv
// Next-PC sequencer: owns the fetch PC and resolves exception, eret, branch and
// jump redirects. A small return-address stack tracks jal/jr pairs and counts
// jr return mispredictions.
module npc_seq #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int unsigned      RAS_DEPTH = 4,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_stall,
  input  logic [31:0]                  i_instr,
  input  logic [WIDTH-1:0]             i_pc4_d,
  input  logic [2:0]                   i_br_type,
  input  logic                         i_zero,
  input  logic                         i_bgez,
  input  logic                         i_bgtz,
  input  logic                         i_blez,
  input  logic                         i_bltz,
  input  logic [1:0]                   i_j_sel,
  input  logic [WIDTH-1:0]             i_rs_val,
  input  logic                         i_exc_req,
  input  logic                         i_eret,
  input  logic [WIDTH-1:0]             i_epc,
  output logic [WIDTH-1:0]             o_pc,
  output logic [WIDTH-1:0]             o_pc4,
  output logic [WIDTH-1:0]             o_ras_top,
  output logic [$clog2(RAS_DEPTH):0]   o_ras_cnt,
  output logic [CNT_W-1:0]             o_ras_miss
);

  localparam int unsigned      PtrW     = $clog2(RAS_DEPTH);
  localparam logic [PtrW:0]    CntFull  = (PtrW + 1)'(RAS_DEPTH);
  // Low 28 bits of a j/jal target come from the instruction index.
  localparam logic [WIDTH-1:0] JLowMask = WIDTH'(28'hFFF_FFFF);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PtrW-1:0]  r_ptr;   // next free slot; top is r_ptr-1
  logic [PtrW:0]    r_cnt;
  logic [CNT_W-1:0] r_miss;

  logic [WIDTH-1:0] w_pc_d;
  logic [WIDTH-1:0] w_boff;
  logic [WIDTH-1:0] w_btgt;
  logic [WIDTH-1:0] w_jtgt;
  logic [PtrW-1:0]  w_top_idx;
  logic             w_taken;
  logic             w_ras_ok;
  logic             w_push;
  logic             w_pop;
  logic             w_miss;
  logic             w_unused;

  assign w_unused  = ^i_instr[31:26];
  assign w_boff    = {{(WIDTH - 18){i_instr[15]}}, i_instr[15:0], 2'b00};
  assign w_btgt    = i_pc4_d + w_boff;
  assign w_jtgt    = (i_pc4_d & ~JLowMask) | WIDTH'({i_instr[25:0], 2'b00});
  assign w_top_idx = r_ptr - PtrW'(1);

  // RAS only moves when the jump redirect itself is the winning rule.
  assign w_ras_ok = !i_exc_req && !i_eret && !i_stall && !w_taken;
  assign w_push   = w_ras_ok && (i_j_sel == 2'd2);
  assign w_pop    = w_ras_ok && (i_j_sel == 2'd3) && (r_cnt != '0);
  assign w_miss   = w_pop && (r_ras[w_top_idx] != i_rs_val);

  assign o_pc       = r_pc;
  assign o_pc4      = r_pc + WIDTH'(4);
  assign o_ras_top  = (r_cnt == '0) ? '0 : r_ras[w_top_idx];
  assign o_ras_cnt  = r_cnt;
  assign o_ras_miss = r_miss;

  // Branch condition decode; type 7 is reserved and never taken.
  always_comb begin
    w_taken = 1'b0;
    case (i_br_type)
      3'd1:    w_taken = i_zero;
      3'd2:    w_taken = !i_zero;
      3'd3:    w_taken = i_bgez;
      3'd4:    w_taken = i_bltz;
      3'd5:    w_taken = i_bgtz;
      3'd6:    w_taken = i_blez;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-PC priority: exception, eret, stall, branch, j/jal, jr, sequential.
  always_comb begin
    w_pc_d = o_pc4;
    if (i_exc_req) begin
      w_pc_d = EXC_VEC;
    end else if (i_eret) begin
      w_pc_d = i_epc;
    end else if (i_stall) begin
      w_pc_d = r_pc;
    end else if (w_taken) begin
      w_pc_d = w_btgt;
    end else if ((i_j_sel == 2'd1) || (i_j_sel == 2'd2)) begin
      w_pc_d = w_jtgt;
    end else if (i_j_sel == 2'd3) begin
      w_pc_d = i_rs_val;
    end
  end

  // Fetch PC register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_d;
    end
  end

  // Return-address stack: circular push overwrites the oldest entry when full.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        r_ras[i] <= '0;
      end
    end else if (w_push) begin
      r_ras[r_ptr] <= i_pc4_d + WIDTH'(4);
      r_ptr        <= r_ptr + PtrW'(1);
      if (r_cnt != CntFull) begin
        r_cnt <= r_cnt + (PtrW + 1)'(1);
      end
    end else if (w_pop) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - (PtrW + 1)'(1);
    end
  end

  // Saturating jr misprediction counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_miss <= '0;
    end else if (w_miss && (r_miss != '1)) begin
      r_miss <= r_miss + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_npc_seq.sv
// Directed bench for npc_seq with hand-computed expectations.
module tb_npc_seq;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] pc4_d;
  logic [2:0]  br_type;
  logic        zero, bgez, bgtz, blez, bltz;
  logic [1:0]  j_sel;
  logic [31:0] rs_val;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] ras_top;
  logic [2:0]  ras_cnt;
  logic [15:0] ras_miss;

  int total = 0;
  int bad   = 0;

  npc_seq dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_stall    (stall),
    .i_instr    (instr),
    .i_pc4_d    (pc4_d),
    .i_br_type  (br_type),
    .i_zero     (zero),
    .i_bgez     (bgez),
    .i_bgtz     (bgtz),
    .i_blez     (blez),
    .i_bltz     (bltz),
    .i_j_sel    (j_sel),
    .i_rs_val   (rs_val),
    .i_exc_req  (exc_req),
    .i_eret     (eret),
    .i_epc      (epc),
    .o_pc       (pc),
    .o_pc4      (pc4),
    .o_ras_top  (ras_top),
    .o_ras_cnt  (ras_cnt),
    .o_ras_miss (ras_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; instr = 0; pc4_d = 0; br_type = 0;
    zero = 0; bgez = 0; bgtz = 0; blez = 0; bltz = 0;
    j_sel = 0; rs_val = 0; exc_req = 0; eret = 0; epc = 0;
  endtask

  initial begin
    idle();
    reset = 0;
    step(); step();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_pc4", pc4, 32'h3004);
    chk("rst_cnt", 32'(ras_cnt), 0);
    chk("rst_top", ras_top, 0);
    chk("rst_miss", 32'(ras_miss), 0);

    reset = 1;
    step(); chk("seq1", pc, 32'h3004);
    step(); chk("seq2", pc, 32'h3008);
    step(); step(); chk("seq4", pc, 32'h3010);
    reset = 0;
    step(); chk("midrst_pc", pc, 32'h3000);
    chk("midrst_cnt", 32'(ras_cnt), 0);
    reset = 1;

    // Branches
    br_type = 1; zero = 1; pc4_d = 32'h3004; instr = 32'h0000_FFFF;
    step(); chk("beq_taken", pc, 32'h3000);
    zero = 0;
    step(); chk("beq_not", pc, 32'h3004);
    br_type = 4; bltz = 1; instr = 32'h0000_0004;
    step(); chk("bltz_taken", pc, 32'h3014);
    bltz = 0; bgez = 1;
    step(); chk("bltz_not", pc, 32'h3018);
    br_type = 2; zero = 0; bgez = 0; instr = 32'h0000_0001;
    step(); chk("bne_taken", pc, 32'h3008);
    br_type = 7; zero = 1; bgez = 1; bgtz = 1; blez = 1; bltz = 1;
    step(); chk("br_rsvd", pc, 32'h300C);
    idle();

    // jal / jr pair
    j_sel = 2; pc4_d = 32'h3008; instr = 32'h0C00_0C10;
    step(); chk("jal_pc", pc, 32'h3040);
    chk("jal_top", ras_top, 32'h300C);
    chk("jal_cnt", 32'(ras_cnt), 1);
    j_sel = 3; rs_val = 32'h300C;
    step(); chk("jr_pc", pc, 32'h300C);
    chk("jr_cnt", 32'(ras_cnt), 0);
    chk("jr_miss", 32'(ras_miss), 0);
    chk("jr_top", ras_top, 0);
    j_sel = 2;
    step(); chk("jal2_cnt", 32'(ras_cnt), 1);
    j_sel = 3; rs_val = 32'h4000;
    step(); chk("jrbad_pc", pc, 32'h4000);
    chk("jrbad_miss", 32'(ras_miss), 1);
    chk("jrbad_cnt", 32'(ras_cnt), 0);

    // Overflow: five pushes into four entries
    j_sel = 2; instr = 32'h0C00_0100;
    for (int k = 1; k <= 5; k++) begin
      pc4_d = 32'h3000 + 32'(k) * 32'h100;
      step();
    end
    chk("ovf_pc", pc, 32'h0400);
    chk("ovf_cnt", 32'(ras_cnt), 4);
    chk("ovf_top", ras_top, 32'h3504);
    j_sel = 3;
    for (int k = 5; k >= 2; k--) begin
      rs_val = 32'h3004 + 32'(k) * 32'h100;
      step();
      chk("pop_pc", pc, rs_val);
      chk("pop_cnt", 32'(ras_cnt), 32'(k - 2));
      chk("pop_miss", 32'(ras_miss), 1);
    end
    rs_val = 32'h3104;
    step(); chk("empty_jr_pc", pc, 32'h3104);
    chk("empty_jr_cnt", 32'(ras_cnt), 0);
    chk("empty_jr_miss", 32'(ras_miss), 1);

    // Stall interactions
    idle();
    stall = 1; j_sel = 2; pc4_d = 32'h3008; instr = 32'h0C00_0C10;
    step(); chk("stall_pc", pc, 32'h3104);
    chk("stall_pc4", pc4, 32'h3108);
    chk("stall_cnt", 32'(ras_cnt), 0);
    exc_req = 1;
    step(); chk("stall_exc", pc, 32'h4180);
    chk("exc_cnt", 32'(ras_cnt), 0);
    exc_req = 0; eret = 1; epc = 32'h3020;
    step(); chk("stall_eret", pc, 32'h3020);
    exc_req = 1;
    step(); chk("exc_over_eret", pc, 32'h4180);
    exc_req = 0;
    step(); chk("eret2", pc, 32'h3020);
    idle();

    // Branch beats jal; branch beats jr
    br_type = 1; zero = 1; j_sel = 2; pc4_d = 32'h3004; instr = 32'h0C00_0010;
    step(); chk("br_jal_pc", pc, 32'h3044);
    chk("br_jal_cnt", 32'(ras_cnt), 0);
    br_type = 0; pc4_d = 32'h3008; instr = 32'h0C00_0C10;
    step(); chk("push1_cnt", 32'(ras_cnt), 1);
    br_type = 1; j_sel = 3; rs_val = 32'h5000; pc4_d = 32'h3004; instr = 32'h0000_0010;
    step(); chk("br_jr_pc", pc, 32'h3044);
    chk("br_jr_cnt", 32'(ras_cnt), 1);
    chk("br_jr_miss", 32'(ras_miss), 1);

    // Wrap-around of the branch add
    idle();
    br_type = 1; zero = 1; pc4_d = 32'hFFFF_FFFC; instr = 32'h0000_0001;
    step(); chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_pc4", pc4, 32'h0000_0004);
    idle();
    step(); chk("wrap_seq", pc, 32'h0000_0004);

    // Reset overrides stall and exception
    reset = 0; stall = 1; exc_req = 1;
    step(); chk("rst_over_pc", pc, 32'h3000);
    chk("rst_over_cnt", 32'(ras_cnt), 0);
    chk("rst_over_miss", 32'(ras_miss), 0);
    chk("rst_over_top", ras_top, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
